// File: rtl/pipeline_hazard_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_hazard_sequencer_pkg : shared encodings for the stall sequencer    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pipeline_hazard_sequencer_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] END_INST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_hazard_sequencer_if : ID/producer inputs and stall/flush outputs   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pipeline_hazard_sequencer_if;
  import pipeline_hazard_sequencer_pkg::*;

  logic [REG_W-1:0]  RsD;
  logic [REG_W-1:0]  RtD;
  logic              UsesRsD;
  logic              UsesRtD;
  logic              BranchD;
  logic              JumpD;
  logic              EndD;
  logic              RegWriteE;
  logic              RegWriteM;
  logic              RegWriteW;
  logic [REG_W-1:0]  WriteRegE;
  logic [REG_W-1:0]  WriteRegM;
  logic [REG_W-1:0]  WriteRegW;
  logic              HoldF;
  logic              HoldD;
  logic              FlushD;
  logic              FlushE;
  logic              Done;
  logic [DATA_W-1:0] StallCycles;

  // CPU datapath side: drives decode/producer info, consumes control
  modport master (
    output RsD, RtD, UsesRsD, UsesRtD, BranchD, JumpD, EndD,
           RegWriteE, RegWriteM, RegWriteW, WriteRegE, WriteRegM, WriteRegW,
    input  HoldF, HoldD, FlushD, FlushE, Done, StallCycles
  );

  modport slave (
    input  RsD, RtD, UsesRsD, UsesRtD, BranchD, JumpD, EndD,
           RegWriteE, RegWriteM, RegWriteW, WriteRegE, WriteRegM, WriteRegW,
    output HoldF, HoldD, FlushD, FlushE, Done, StallCycles
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_sequencer_hazard_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_match : combinational RAW comparator, both ID sources vs E/M/W       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hazard_match
  import pipeline_hazard_sequencer_pkg::*;
#(
  parameter bit WB_WRITE_FIRST = 1'b0
) (
  input  wire logic [REG_W-1:0] rs_i,
  input  wire logic [REG_W-1:0] rt_i,
  input  wire logic             uses_rs_i,
  input  wire logic             uses_rt_i,
  input  wire logic             regwrite_e_i,
  input  wire logic             regwrite_m_i,
  input  wire logic             regwrite_w_i,
  input  wire logic [REG_W-1:0] writereg_e_i,
  input  wire logic [REG_W-1:0] writereg_m_i,
  input  wire logic [REG_W-1:0] writereg_w_i,
  output logic                  haz_o
);

  logic w_rs_hit;
  logic w_rt_hit;

  // $0 is hard-wired, so it can never be a true dependency
  function automatic logic src_match(input logic [REG_W-1:0] r);
    logic m;
    m = (regwrite_e_i && (writereg_e_i == r)) ||
        (regwrite_m_i && (writereg_m_i == r)) ||
        (!WB_WRITE_FIRST && regwrite_w_i && (writereg_w_i == r));
    return (r != '0) && m;
  endfunction

  always_comb begin
    w_rs_hit = uses_rs_i && src_match(rs_i);
    w_rt_hit = uses_rt_i && src_match(rt_i);
    haz_o    = w_rs_hit || w_rt_hit;
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_hazard_sequencer : RAW stall, branch/jump shadow and end drain    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipeline_hazard_sequencer
  import pipeline_hazard_sequencer_pkg::*;
#(
  parameter int BRANCH_BUBBLES = 3,
  parameter int DRAIN_CYCLES   = 4,
  parameter bit WB_WRITE_FIRST = 1'b0,
  parameter int CNT_W          = 4
) (
  input  wire logic CLK,
  input  wire logic RST,
  pipeline_hazard_sequencer_if.slave hz
);

  localparam logic [CNT_W-1:0] C_BR_LOAD = CNT_W'(BRANCH_BUBBLES - 1);
  localparam logic [CNT_W-1:0] C_DR_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  stall_q, stall_d;

  logic w_haz;
  logic w_hold_f;
  logic w_hold_d;
  logic w_flush_d;
  logic w_flush_e;
  logic w_done;

  hazard_match #(
    .WB_WRITE_FIRST (WB_WRITE_FIRST)
  ) u_hazard_match (
    .rs_i         (hz.RsD),
    .rt_i         (hz.RtD),
    .uses_rs_i    (hz.UsesRsD),
    .uses_rt_i    (hz.UsesRtD),
    .regwrite_e_i (hz.RegWriteE),
    .regwrite_m_i (hz.RegWriteM),
    .regwrite_w_i (hz.RegWriteW),
    .writereg_e_i (hz.WriteRegE),
    .writereg_m_i (hz.WriteRegM),
    .writereg_w_i (hz.WriteRegW),
    .haz_o        (w_haz)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_hold_f  = 1'b0;
    w_hold_d  = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_done    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (hz.EndD) begin
          w_hold_f  = 1'b1;
          w_flush_d = 1'b1;
          cnt_d     = C_DR_LOAD;
          state_d   = ST_DRAIN;
        end else if (w_haz) begin
          w_hold_f  = 1'b1;
          w_hold_d  = 1'b1;
          w_flush_e = 1'b1;
        end else if (hz.BranchD) begin
          w_flush_d = 1'b1;
          // A single-bubble branch resolves in time for the PC to move now
          if (BRANCH_BUBBLES > 1) begin
            w_hold_f = 1'b1;
            cnt_d    = C_BR_LOAD;
            state_d  = ST_BR_WAIT;
          end
        end else if (hz.JumpD) begin
          w_flush_d = 1'b1;
        end
      end

      ST_BR_WAIT: begin
        w_flush_d = 1'b1;
        if (cnt_q > C_ONE) begin
          w_hold_f = 1'b1;
          cnt_d    = cnt_q - C_ONE;
        end else begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_DRAIN: begin
        w_hold_f  = 1'b1;
        w_flush_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end

      ST_DONE: begin
        w_hold_f  = 1'b1;
        w_flush_d = 1'b1;
        w_done    = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    stall_d = w_hold_f ? sat_inc(stall_q) : stall_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign hz.HoldF       = w_hold_f;
  assign hz.HoldD       = w_hold_d;
  assign hz.FlushD      = w_flush_d;
  assign hz.FlushE      = w_flush_e;
  assign hz.Done        = w_done;
  assign hz.StallCycles = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipeline_hazard_sequencer : scoreboard bench with schedule-based model   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipeline_hazard_sequencer;

  localparam int BRB  = 3;
  localparam int DRC  = 4;
  localparam bit WBWF = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_sequencer_if hz();

  pipeline_hazard_sequencer #(
    .BRANCH_BUBBLES (BRB),
    .DRAIN_CYCLES   (DRC),
    .WB_WRITE_FIRST (WBWF),
    .CNT_W          (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .hz  (hz)
  );

  typedef struct packed {
    logic        hf;
    logic        hd;
    logic        fd;
    logic        fe;
    logic        dn;
    logic [31:0] sc;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;

  // Model: a list of cycles whose outputs are already fixed (branch shadow or
  // drain), plus a sticky done flag and a stall counter.
  bit          sched[$];
  bit          m_drain = 1'b0;
  bit          m_done  = 1'b0;
  logic [31:0] stalls  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("HoldF",       32'(hz.HoldF),  32'(me.hf));
      chk("HoldD",       32'(hz.HoldD),  32'(me.hd));
      chk("FlushD",      32'(hz.FlushD), 32'(me.fd));
      chk("FlushE",      32'(hz.FlushE), 32'(me.fe));
      chk("Done",        32'(hz.Done),   32'(me.dn));
      chk("StallCycles", hz.StallCycles, me.sc);
    end
  end

  function automatic bit hits(input logic [4:0] r);
    return (r != 5'd0) &&
           ((hz.RegWriteE && hz.WriteRegE == r) ||
            (hz.RegWriteM && hz.WriteRegM == r) ||
            (!WBWF && hz.RegWriteW && hz.WriteRegW == r));
  endfunction

  // Drive one cycle of inputs, predict its outputs, then advance the model.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                      input bit urs, input bit urt, input bit br, input bit jp, input bit en,
                      input bit rwe, input bit rwm, input bit rww,
                      input logic [4:0] wre, input logic [4:0] wrm, input logic [4:0] wrw,
                      input bit r);
    exp_t e;
    bit   hzd;
    hz.RsD = rs;  hz.RtD = rt;  hz.UsesRsD = urs;  hz.UsesRtD = urt;
    hz.BranchD = br;  hz.JumpD = jp;  hz.EndD = en;
    hz.RegWriteE = rwe;  hz.RegWriteM = rwm;  hz.RegWriteW = rww;
    hz.WriteRegE = wre;  hz.WriteRegM = wrm;  hz.WriteRegW = wrw;
    rst = r;
    hzd = (urs && hits(rs)) || (urt && hits(rt));
    e = '0;
    e.sc = stalls;
    if (m_done) begin
      e.hf = 1'b1; e.fd = 1'b1; e.dn = 1'b1;
    end else if (sched.size() > 0) begin
      e.hf = sched[0]; e.fd = 1'b1;
    end else if (en) begin
      e.hf = 1'b1; e.fd = 1'b1;
    end else if (hzd) begin
      e.hf = 1'b1; e.hd = 1'b1; e.fe = 1'b1;
    end else if (br) begin
      e.fd = 1'b1; e.hf = (BRB > 1);
    end else if (jp) begin
      e.fd = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk);
    if (r) begin
      sched.delete();
      m_drain = 1'b0;
      m_done  = 1'b0;
      stalls  = '0;
    end else begin
      if (e.hf && stalls != 32'hFFFF_FFFF) stalls = stalls + 32'd1;
      if (m_done) begin
      end else if (sched.size() > 0) begin
        void'(sched.pop_front());
        if (sched.size() == 0 && m_drain) m_done = 1'b1;
      end else if (en) begin
        m_drain = 1'b1;
        repeat (DRC) sched.push_back(1'b1);
      end else if (!hzd && br && BRB > 1) begin
        for (int i = 0; i < BRB - 1; i++) sched.push_back(i < BRB - 2);
      end
    end
    #1;
  endtask

  task automatic idle(input bit r);
    step(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, r);
  endtask

  task automatic rstep(input bit r);
    bit br;
    bit jp;
    br = ($urandom_range(0, 7) == 0);
    jp = !br && ($urandom_range(0, 7) == 0);
    step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), br, jp,
         ($urandom_range(0, 79) == 0),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         r);
  endtask

  initial begin
    hz.RsD = '0; hz.RtD = '0; hz.UsesRsD = 0; hz.UsesRtD = 0;
    hz.BranchD = 0; hz.JumpD = 0; hz.EndD = 0;
    hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.WriteRegE = '0; hz.WriteRegM = '0; hz.WriteRegW = '0;
    repeat (2) @(posedge clk);
    #1;
    idle(0);

    // add $3 moving E -> M -> W while the consumer waits in ID
    step(5'd3, 5'd0, 1, 0, 0, 0, 0, 1, 0, 0, 5'd3, 5'd0, 5'd0, 0);
    step(5'd3, 5'd0, 1, 0, 0, 0, 0, 0, 1, 0, 5'd0, 5'd3, 5'd0, 0);
    step(5'd3, 5'd0, 1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd3, 0);
    step(5'd3, 5'd0, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // $0 never stalls
    step(5'd0, 5'd0, 1, 1, 0, 0, 0, 1, 1, 1, 5'd0, 5'd0, 5'd0, 0);

    // beq without hazard, then beq with RtD hazard in MEM
    step(5'd1, 5'd2, 1, 1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    repeat (3) idle(0);
    step(5'd1, 5'd2, 1, 1, 1, 0, 0, 0, 1, 0, 5'd0, 5'd2, 5'd0, 0);
    step(5'd1, 5'd2, 1, 1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    repeat (3) idle(0);

    // jump, then jr stalled by its Rs producer
    step(5'd31, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(5'd31, 5'd0, 1, 0, 0, 1, 0, 1, 0, 0, 5'd31, 5'd0, 5'd0, 0);
    idle(0);

    // end with competing branch/hazard inputs, drain to done, reset from done
    step(5'd4, 5'd4, 1, 1, 1, 0, 1, 1, 0, 0, 5'd4, 5'd0, 5'd0, 0);
    repeat (6) step(5'd4, 5'd4, 1, 1, 1, 0, 0, 1, 1, 1, 5'd4, 5'd4, 5'd4, 0);
    idle(1);
    idle(0);

    // reset held two cycles in the middle of a drain
    step(5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(0);
    idle(1);
    idle(1);
    repeat (2) idle(0);

    for (int n = 0; n < 3000; n++) begin
      rstep((m_done && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0));
    end

    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_scoreboard actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Replaces the ad-hoc stall flag, stall counter and end-of-program logic scattered across the CPU top.
- Detects RAW hazards against EX/MEM/WB producers, sequences the 3-bubble branch shadow (branches resolve in MEM) and the 1-bubble jump shadow (jumps resolve in ID).
- Drains the pipeline after the end instruction and signals when data memory may be dumped.

Parameters:
- BRANCH_BUBBLES, 3, number of NOPs inserted into ID after a branch leaves ID (minimum 1).
- DRAIN_CYCLES, 4, cycles to wait after the end instruction leaves ID before asserting Done (minimum 1).
- WB_WRITE_FIRST, 0, 1 means the register file writes before it reads in the same cycle, so WB producers need no stall.
- CNT_W, 4, width of the internal bubble/drain counter; must satisfy 2^CNT_W > max(BRANCH_BUBBLES, DRAIN_CYCLES).

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  synchronous reset, active-high.
- RsD  in  5  source register 1 of InstrD.
- RtD  in  5  source register 2 of InstrD.
- UsesRsD  in  1  InstrD reads RsD (includes jr).
- UsesRtD  in  1  InstrD reads RtD (includes R-type, sw, beq/bne).
- BranchD  in  1  InstrD is beq/bne.
- JumpD  in  1  InstrD is j/jal/jr.
- EndD  in  1  InstrD equals END_INST.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  producer write enables.
- WriteRegE, WriteRegM, WriteRegW  in  5 each  producer destination registers.
- HoldF  out  1  PCF keeps its value at the next edge.
- HoldD  out  1  InstrD and PCPlus4D keep their values.
- FlushD  out  1  InstrD loads NOP_INST at the next edge.
- FlushE  out  1  ID/EX control signals load zero (bubble) at the next edge.
- Done  out  1  pipeline fully drained; level output.
- StallCycles  out  32  saturating count of cycles with HoldF=1.

Behaviour:
- Decided: one clock; reset is synchronous and active-high. Clock port is CLK, reset port is RST.
- Reset: state RUN, counter 0, StallCycles 0. All outputs are 0 in the cycle after RST is sampled high. Reset mid-branch or mid-drain aborts the sequence immediately.
- Hazard term (combinational):
  - Haz = UsesRsD && RsD!=0 && match(RsD), OR UsesRtD && RtD!=0 && match(RtD).
  - match(r) = (RegWriteE && WriteRegE==r) || (RegWriteM && WriteRegM==r) || (!WB_WRITE_FIRST && RegWriteW && WriteRegW==r).
- Outputs are Moore/Mealy from the state; all are combinational from registered state plus ID inputs.
- States:
  - RUN, priority EndD > Haz > BranchD > JumpD:
    - EndD: HoldF=1, FlushD=1; cnt<=DRAIN_CYCLES-1; go DRAIN.
    - Haz: HoldF=1, HoldD=1, FlushE=1; stay RUN; the instruction re-evaluates next cycle.
    - BranchD (no Haz): HoldF=1, FlushD=1; cnt<=BRANCH_BUBBLES-1; go BR_WAIT.
    - JumpD (no Haz): FlushD=1, HoldF=0, so the PC takes the jump target; stay RUN.
    - Otherwise: all 0.
  - BR_WAIT:
    - FlushD=1.
    - HoldF=1 while cnt>1. HoldF=0 when cnt==1, so the PC loads the MEM-stage target or fall-through.
    - cnt decrements each cycle; at cnt==1 go RUN.
    - With BRANCH_BUBBLES==1, skip BR_WAIT and set HoldF=0 in the RUN cycle.
  - DRAIN:
    - HoldF=1, FlushD=1; ID inputs are ignored.
    - cnt decrements; when cnt==0 go DONE.
  - DONE: HoldF=1, FlushD=1, Done=1 until reset.
- FlushE is asserted only in RUN on Haz. HoldD and FlushD are never asserted together.
- StallCycles increments when HoldF=1 and saturates at 0xFFFFFFFF.
- Hazard/branch overlap: a branch whose operand is in flight stalls via Haz first, then enters BR_WAIT once Haz clears. jr follows the same rule via UsesRsD.
- Bubbles in ID (NOP_INST) decode with Uses*=0, Branch=0, Jump=0, so they never create hazards.

Decomposition:
- Shared package/config.v holds:
  - state encoding RUN=2'd0, BR_WAIT=2'd1, DRAIN=2'd2, DONE=2'd3;
  - NOP_INST and END_INST (already defined there).
- One natural sub-module, hazard_match: the combinational RAW comparator (RsD/RtD against the three producers, WB_WRITE_FIRST parameter). Instantiate it once with both sources.

Test Plan:
- RST high 2 cycles mid-DRAIN -> cycle after: all outputs 0, state RUN, StallCycles=0.
- add $3 in EX (RegWriteE=1, WriteRegE=3), InstrD uses RsD=3 -> HoldF=HoldD=FlushE=1 for 3 cycles (E, M, W with WB_WRITE_FIRST=0), then all 0; StallCycles=3. With WB_WRITE_FIRST=1 the stall lasts 2 cycles. RsD=0 with WriteRegE=0 -> no stall.
- beq with no hazard, BRANCH_BUBBLES=3 -> FlushD=1 for 3 consecutive cycles; HoldF=1,1,0; then RUN; StallCycles+=2.
- beq with RtD hazard in MEM -> 1 cycle of Haz stall (FlushE=1), then the 3-cycle branch sequence.
- j in ID -> single cycle FlushD=1, HoldF=0; no other output asserted.
- EndD=1, DRAIN_CYCLES=4 -> HoldF=FlushD=1 thereafter; Done rises exactly 4 cycles after EndD is sampled and stays high; concurrent BranchD/Haz inputs are ignored.
